// File: rtl/seg7_pkg.sv
// Shared segment encodings and helpers for the 7-segment scan driver.
// Patterns are active-high with bit0 = a ... bit6 = g.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Non-BCD codes (10..15) show a dash so a corrupted counter is visible.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] pattern;
        case (bcd)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

    function automatic logic [6:0] seg_polarity(input logic [6:0] pattern, input logic active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-high 7-segment decoder.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    assign seg_o = bcd_to_seg(bcd_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: refresh prescaler, digit scan, frame-coherent
// snapshot of the BCD inputs, leading-zero blanking and registered pin outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      blank_lz,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_start
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0]      CNT_LAST    = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST    = IDX_W'(NUM_DIGITS - 1);
    localparam logic                  SEG_LOW     = (SEG_ACTIVE_LOW != 0);
    localparam logic                  AN_LOW      = (AN_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_IDLE     = AN_LOW ? '1 : '0;
    localparam logic [6:0]            SEG_IDLE    = seg_polarity(SEG_OFF, SEG_LOW);
    localparam logic                  DP_IDLE     = SEG_LOW;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [3:0]            snap_q [NUM_DIGITS];
    logic [3:0]            snap_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] snap_dp_q, snap_dp_d;
    logic                  frame_start_q, frame_start_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  cnt_wrap;
    logic                  frame_wrap;
    logic [NUM_DIGITS:0]   zeros_from;
    logic                  blank_cur;
    logic [NUM_DIGITS-1:0] an_onehot;
    logic [3:0]            cur_digit;
    logic [6:0]            cur_seg;

    // Scan timing and snapshot capture; the snapshot only changes as idx wraps to 0.
    always_comb begin
        cnt_wrap      = (cnt_q == CNT_LAST);
        frame_wrap    = cnt_wrap && (idx_q == IDX_LAST);
        cnt_d         = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d         = idx_q;
        snap_d        = snap_q;
        snap_dp_d     = snap_dp_q;
        frame_start_d = frame_wrap;
        if (cnt_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        if (frame_wrap) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                snap_d[i] = digits_in[4*i +: 4];
            end
            snap_dp_d = dp_in;
        end
    end

    // zeros_from[i] is set when snapshot digits NUM_DIGITS-1 down to i are all zero.
    always_comb begin
        zeros_from[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zeros_from[i] = zeros_from[i+1] && (snap_q[i] == 4'd0);
        end
    end

    assign cur_digit = snap_q[idx_q];
    assign blank_cur = blank_lz && (idx_q != '0) && zeros_from[idx_q];

    bcd_to_seg7 u_decoder (
        .bcd_i (cur_digit),
        .seg_o (cur_seg)
    );

    // Blanked digits keep their anode so every digit has the same duty cycle.
    always_comb begin
        an_onehot        = '0;
        an_onehot[idx_q] = 1'b1;
        an_d             = AN_LOW ? ~an_onehot : an_onehot;
        seg_d            = seg_polarity(blank_cur ? SEG_OFF : cur_seg, SEG_LOW);
        dp_d             = SEG_LOW ? ~snap_dp_q[idx_q] : snap_dp_q[idx_q];
    end

    // NOTE: the snapshot array is reset too, so the first frame shows a defined "0".
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            snap_q        <= '{default: '0};
            snap_dp_q     <= '0;
            frame_start_q <= 1'b0;
            an_q          <= AN_IDLE;
            seg_q         <= SEG_IDLE;
            dp_q          <= DP_IDLE;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            snap_dp_q     <= snap_dp_d;
            frame_start_q <= frame_start_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 4-cycle refresh, active-low pins).
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int RD    = 4;
    localparam int FRAME = N * RD;

    localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic           clk;
    logic           reset;
    logic [4*N-1:0] digits_in;
    logic [N-1:0]   dp_in;
    logic           blank_lz;
    logic [N-1:0]   an;
    logic [6:0]     seg;
    logic           dp;
    logic           frame_start;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(
        .NUM_DIGITS     (N),
        .REFRESH_DIV    (RD),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_lz    (blank_lz),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-high glyph for a BCD code; anything above 9 is a dash.
    function automatic logic [6:0] glyph(input int v);
        if (v > 9) return 7'h40;
        return SEG_TAB[v];
    endfunction

    function automatic logic [N-1:0] an_for(input int d);
        logic [N-1:0] a;
        a    = '1;
        a[d] = 1'b0;
        return a;
    endfunction

    // Reference model: output slot derived from the number of clocks since reset.
    int           m_cycle;
    int           m_digit [N];
    logic         m_dp    [N];
    int           m_pos, m_sel;
    logic         m_blank;
    logic [N-1:0] exp_an;
    logic [6:0]   exp_seg;
    logic         exp_dp;
    logic         exp_fs;

    always @(posedge clk) begin
        if (reset) begin
            m_cycle = 0;
            for (int i = 0; i < N; i++) begin
                m_digit[i] = 0;
                m_dp[i]    = 1'b0;
            end
            exp_an  = '1;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
            exp_fs  = 1'b0;
        end else begin
            m_pos   = m_cycle % FRAME;
            m_sel   = m_pos / RD;
            m_blank = 1'b0;
            if (blank_lz && m_sel > 0) begin
                m_blank = 1'b1;
                for (int j = m_sel; j < N; j++)
                    if (m_digit[j] != 0) m_blank = 1'b0;
            end
            exp_an  = an_for(m_sel);
            exp_seg = m_blank ? 7'h7F : ~glyph(m_digit[m_sel]);
            exp_dp  = ~m_dp[m_sel];
            exp_fs  = (m_pos == FRAME - 1);
            if (exp_fs) begin
                for (int i = 0; i < N; i++) begin
                    m_digit[i] = int'(digits_in[4*i +: 4]);
                    m_dp[i]    = dp_in[i];
                end
            end
            m_cycle++;
        end
    end

    // Returns at the falling edge on which frame_start is high.
    task automatic wait_fs(input string tag);
        int n = 0;
        checks++;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 4 * FRAME);
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL %s frame_start timeout: got %b expected 1", tag, frame_start);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        digits_in = '0;
        dp_in     = '0;
        blank_lz  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got an=%b seg=%h dp=%b fs=%b expected an=1111 seg=7f dp=1 fs=0",
                     an, seg, dp, frame_start);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (an !== 4'b1110 || seg !== ~7'h3F || dp !== 1'b1 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL first_output: got an=%b seg=%h dp=%b fs=%b expected an=1110 seg=%h dp=1 fs=0",
                     an, seg, dp, frame_start, ~7'h3F);
        end
    endtask

    task automatic test_full_frame();
        logic [6:0] tab [N];
        tab = '{~7'h66, ~7'h4F, ~7'h5B, ~7'h06};
        digits_in = 16'h1234;
        dp_in     = '0;
        blank_lz  = 1'b0;
        wait_fs("full_frame");
        wait_fs("full_frame");
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (an !== an_for(c / RD) || seg !== tab[c / RD] || dp !== 1'b1 ||
                frame_start !== (c == FRAME - 1)) begin
                errors++;
                $display("FAIL full_frame c=%0d: got an=%b seg=%h dp=%b fs=%b expected an=%b seg=%h dp=1 fs=%b",
                         c, an, seg, dp, frame_start, an_for(c / RD), tab[c / RD], c == FRAME - 1);
            end
        end
    endtask

    task automatic test_blanking();
        logic [6:0] tab [N];
        blank_lz  = 1'b1;
        dp_in     = '0;
        digits_in = 16'h0050;
        tab = '{~7'h3F, ~7'h6D, 7'h7F, 7'h7F};
        wait_fs("blank_0050");
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (an !== an_for(c / RD) || seg !== tab[c / RD] || dp !== 1'b1) begin
                errors++;
                $display("FAIL blank_0050 c=%0d: got an=%b seg=%h dp=%b expected an=%b seg=%h dp=1",
                         c, an, seg, dp, an_for(c / RD), tab[c / RD]);
            end
        end
        digits_in = 16'h0000;
        tab = '{~7'h3F, 7'h7F, 7'h7F, 7'h7F};
        wait_fs("blank_0000");
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (an !== an_for(c / RD) || seg !== tab[c / RD]) begin
                errors++;
                $display("FAIL blank_0000 c=%0d: got an=%b seg=%h expected an=%b seg=%h",
                         c, an, seg, an_for(c / RD), tab[c / RD]);
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_invalid_dp();
        logic [6:0] tab [N];
        logic       dtab [N];
        tab  = '{~7'h3F, ~7'h40, ~7'h3F, ~7'h3F};
        dtab = '{1'b1, 1'b0, 1'b1, 1'b1};
        digits_in = 16'h00A0;
        dp_in     = 4'b0010;
        blank_lz  = 1'b0;
        wait_fs("invalid_dp");
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (an !== an_for(c / RD) || seg !== tab[c / RD] || dp !== dtab[c / RD]) begin
                errors++;
                $display("FAIL invalid_dp c=%0d: got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b",
                         c, an, seg, dp, an_for(c / RD), tab[c / RD], dtab[c / RD]);
            end
        end
        dp_in = '0;
    endtask

    task automatic test_no_tearing();
        logic [6:0] tab [N];
        tab = '{~7'h66, ~7'h4F, ~7'h5B, ~7'h06};
        digits_in = 16'h1234;
        wait_fs("no_tearing");
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (an !== an_for(c / RD) || seg !== tab[c / RD]) begin
                errors++;
                $display("FAIL no_tearing c=%0d: got an=%b seg=%h expected an=%b seg=%h",
                         c, an, seg, an_for(c / RD), tab[c / RD]);
            end
            if (c == 2 * RD) digits_in = 16'h5678;
        end
        @(negedge clk);
        checks++;
        if (an !== 4'b1110 || seg !== ~7'h7F) begin
            errors++;
            $display("FAIL no_tearing_new: got an=%b seg=%h expected an=1110 seg=%h", an, seg, ~7'h7F);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        wait_fs("reset_mid");
        while (an !== 4'b1011 && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (an !== 4'b1011) begin
            errors++;
            $display("FAIL reset_mid_reach: got an=%b expected 1011", an);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_values: got an=%b seg=%h dp=%b fs=%b expected an=1111 seg=7f dp=1 fs=0",
                     an, seg, dp, frame_start);
        end
        reset = 1'b0;
        for (int c = 0; c <= RD; c++) begin
            @(negedge clk);
            checks++;
            if (an !== an_for(c / RD) || seg !== ~7'h3F || dp !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid_restart c=%0d: got an=%b seg=%h dp=%b expected an=%b seg=%h dp=1",
                         c, an, seg, dp, an_for(c / RD), ~7'h3F);
            end
        end
    endtask

    task automatic test_random();
        logic [4*N-1:0] v;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            checks++;
            if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || frame_start !== exp_fs) begin
                errors++;
                $display("FAIL random c=%0d: got an=%b seg=%h dp=%b fs=%b expected an=%b seg=%h dp=%b fs=%b",
                         c, an, seg, dp, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 5) == 0) begin
                for (int i = 0; i < N; i++)
                    v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
                digits_in = v;
                dp_in     = N'($urandom);
            end
            if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
        end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_full_frame();
        test_blanking();
        test_invalid_dp();
        test_no_tearing();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
